// File: rtl/complex_mult_tb_pkg.sv
// Shared definitions for the complex-multiplier driver: FSM encoding, LFSR taps and default seed.
package complex_mult_tb_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSwrst,
    StDrive,
    StWaitRes,
    StDone
  } state_e;

  // Feedback taps at bits 31, 21, 1 and 0.
  localparam logic [31:0] LfsrTapMask = 32'h8020_0003;
  localparam logic [31:0] DefaultSeed = 32'h0000_0001;

  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return {v[30:0], ^(v & LfsrTapMask)};
  endfunction

endpackage

// File: rtl/lfsr_32.sv
// 32-bit Fibonacci LFSR with synchronous reset/load to a seed and an explicit advance strobe.
module lfsr_32
  import complex_mult_tb_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic [31:0] seed_i,
  input  logic        advance_i,
  output logic [31:0] value_o
);

  logic [31:0] value_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || load_i) begin
      value_q <= seed_i;
    end else if (advance_i) begin
      value_q <= lfsr_next(value_q);
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/driver_complex_multiplier.sv
// Drives pseudo-random operand pairs into a complex multiplier over valid/ready handshakes
// and captures results, with per-wait timeout and a run counter.
module driver_complex_multiplier
  import complex_mult_tb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned NUM_TRANS       = 16,
  parameter logic [31:0] LFSR_SEED       = DefaultSeed,
  parameter int unsigned RES_READY_DELAY = 0,
  parameter int unsigned TIMEOUT         = 1023
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  output logic                    sw_rst_o,
  output logic                    op_val_o,
  output logic [DATA_WIDTH-1:0]   op_1_re_o,
  output logic [DATA_WIDTH-1:0]   op_1_im_o,
  output logic [DATA_WIDTH-1:0]   op_2_re_o,
  output logic [DATA_WIDTH-1:0]   op_2_im_o,
  input  logic                    op_ready_i,
  input  logic                    res_val_i,
  output logic                    res_ready_o,
  input  logic [2*DATA_WIDTH-1:0] result_re_i,
  input  logic [2*DATA_WIDTH-1:0] result_im_i,
  output logic [2*DATA_WIDTH-1:0] last_re_o,
  output logic [2*DATA_WIDTH-1:0] last_im_o,
  output logic [15:0]             trans_cnt_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    timeout_err_o
);

  localparam logic [31:0] Seed       = (LFSR_SEED == '0) ? 32'h0000_0001 : LFSR_SEED;
  localparam logic [15:0] WaitLast   = 16'(TIMEOUT - 1);
  localparam logic [15:0] NumTrans   = 16'(NUM_TRANS);
  localparam logic [15:0] ReadyDelay = 16'(RES_READY_DELAY);

  state_e                  state_q;
  logic                    sw_rst_q, op_val_q, res_ready_q, busy_q, done_q, timeout_err_q;
  logic [DATA_WIDTH-1:0]   op_1_re_q, op_1_im_q, op_2_re_q, op_2_im_q;
  logic [2*DATA_WIDTH-1:0] last_re_q, last_im_q;
  logic [15:0]             trans_cnt_q, wait_cnt_q;
  logic [31:0]             lfsr_value;

  logic        start_ok, op_hs, res_hs, wait_expired;
  logic [15:0] wait_inc, trans_inc;

  assign start_ok     = start_i && (state_q == StIdle || state_q == StDone);
  assign op_hs        = op_val_q && op_ready_i;
  assign res_hs       = res_ready_q && res_val_i;
  assign wait_expired = (wait_cnt_q == WaitLast);
  assign wait_inc     = wait_cnt_q + 16'd1;
  assign trans_inc    = trans_cnt_q + 16'd1;

  lfsr_32 u_lfsr (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (start_ok),
    .seed_i   (Seed),
    .advance_i(op_hs),
    .value_o  (lfsr_value)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      sw_rst_q      <= 1'b0;
      op_val_q      <= 1'b0;
      res_ready_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      op_1_re_q     <= '0;
      op_1_im_q     <= '0;
      op_2_re_q     <= '0;
      op_2_im_q     <= '0;
      last_re_q     <= '0;
      last_im_q     <= '0;
      trans_cnt_q   <= '0;
      wait_cnt_q    <= '0;
    end else begin
      sw_rst_q <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (start_i) begin
            state_q       <= StSwrst;
            sw_rst_q      <= 1'b1;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
            trans_cnt_q   <= '0;
            timeout_err_q <= 1'b0;
          end
        end
        StSwrst: begin
          state_q    <= StDrive;
          op_val_q   <= 1'b1;
          wait_cnt_q <= '0;
          op_1_re_q  <= lfsr_value[0 +: DATA_WIDTH];
          op_1_im_q  <= lfsr_value[8 +: DATA_WIDTH];
          op_2_re_q  <= lfsr_value[16 +: DATA_WIDTH];
          op_2_im_q  <= lfsr_value[24 +: DATA_WIDTH];
        end
        StDrive: begin
          if (op_hs) begin
            state_q     <= StWaitRes;
            op_val_q    <= 1'b0;
            wait_cnt_q  <= '0;
            res_ready_q <= (ReadyDelay == 16'd0);
          end else if (wait_expired) begin
            state_q       <= StDone;
            op_val_q      <= 1'b0;
            timeout_err_q <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b1;
          end else begin
            wait_cnt_q <= wait_inc;
          end
        end
        StWaitRes: begin
          if (res_hs) begin
            last_re_q   <= result_re_i;
            last_im_q   <= result_im_i;
            trans_cnt_q <= trans_inc;
            res_ready_q <= 1'b0;
            if (trans_inc == NumTrans) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              // LFSR already advanced on the operand handshake; load the next pair.
              state_q    <= StDrive;
              op_val_q   <= 1'b1;
              wait_cnt_q <= '0;
              op_1_re_q  <= lfsr_value[0 +: DATA_WIDTH];
              op_1_im_q  <= lfsr_value[8 +: DATA_WIDTH];
              op_2_re_q  <= lfsr_value[16 +: DATA_WIDTH];
              op_2_im_q  <= lfsr_value[24 +: DATA_WIDTH];
            end
          end else if (wait_expired) begin
            state_q       <= StDone;
            res_ready_q   <= 1'b0;
            timeout_err_q <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b1;
          end else begin
            wait_cnt_q  <= wait_inc;
            res_ready_q <= (wait_inc >= ReadyDelay);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign sw_rst_o      = sw_rst_q;
  assign op_val_o      = op_val_q;
  assign res_ready_o   = res_ready_q;
  assign op_1_re_o     = op_1_re_q;
  assign op_1_im_o     = op_1_im_q;
  assign op_2_re_o     = op_2_re_q;
  assign op_2_im_o     = op_2_im_q;
  assign last_re_o     = last_re_q;
  assign last_im_o     = last_im_q;
  assign trans_cnt_o   = trans_cnt_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign timeout_err_o = timeout_err_q;

endmodule
